// File: rtl/line_ring_sched_pkg.sv
// Shared types and constants for the GBA line-cache ring scheduler.
// Contents: scheduler state enum, default ring depth, GBA visible line count,
// and the line-index width used on the reader-side ports.
package line_ring_sched_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } sched_state_t;

    localparam int unsigned LINE_SLOTS = 4;
    localparam int unsigned GBA_LINES  = 160;
    localparam int unsigned LINE_IDX_W = 8;

endpackage

// File: rtl/line_ring_sched_if.sv
// Bundle of the capture-side, image-generator-side and status signals of the
// line ring scheduler.
// master: capture/image-gen side (drives the pulses, observes slots/status).
// slave : the scheduler (observes the pulses, drives slots/status).
interface line_ring_sched_if
    import line_ring_sched_pkg::*;
#(
    parameter int unsigned SLOT_W = $clog2(LINE_SLOTS)
);
    logic                  wrFrameStart;
    logic                  wrLineDone;
    logic                  nextLine;
    logic                  cacheUpdate;
    logic [SLOT_W-1:0]     wrSlot;
    logic [SLOT_W-1:0]     prevSlot;
    logic [SLOT_W-1:0]     curSlot;
    logic [SLOT_W-1:0]     nextSlot;
    logic [LINE_IDX_W-1:0] lineIdx;
    logic                  sameLine;
    logic                  newFrameOut;
    logic [SLOT_W-1:0]     pending;
    logic                  overflow;

    modport master (
        output wrFrameStart, wrLineDone, nextLine, cacheUpdate,
        input  wrSlot, prevSlot, curSlot, nextSlot, lineIdx,
               sameLine, newFrameOut, pending, overflow
    );

    modport slave (
        input  wrFrameStart, wrLineDone, nextLine, cacheUpdate,
        output wrSlot, prevSlot, curSlot, nextSlot, lineIdx,
               sameLine, newFrameOut, pending, overflow
    );

endinterface

// File: rtl/line_ring_sched_slot_neighbour_calc.sv
// Derives the prev/next neighbour slots of the current line with top/bottom
// edge replication. The candidates are registered one cycle after the ring
// state changes and only published to the reader on cache_update, so the
// image generator never sees slots move mid-line.
// Ports: pxlClk/rst (sync, active-high), cache_update publish strobe,
// cur_slot/pending/line_idx ring state, prev_slot/next_slot published slots.
module line_ring_sched_slot_neighbour_calc
    import line_ring_sched_pkg::*;
#(
    parameter int unsigned SLOT_W          = 2,
    parameter int unsigned LINES_PER_FRAME = GBA_LINES
) (
    input  logic                  pxlClk,
    input  logic                  rst,
    input  logic                  cache_update,
    input  logic [SLOT_W-1:0]     cur_slot,
    input  logic [SLOT_W-1:0]     pending,
    input  logic [LINE_IDX_W-1:0] line_idx,
    output logic [SLOT_W-1:0]     prev_slot,
    output logic [SLOT_W-1:0]     next_slot
);
    localparam logic [LINE_IDX_W-1:0] LAST_IDX = LINE_IDX_W'(LINES_PER_FRAME - 1);
    localparam logic [SLOT_W-1:0]     ONE      = SLOT_W'(1);

    logic [SLOT_W-1:0] prev_cand_q, next_cand_q;
    logic [SLOT_W-1:0] prev_cand_d, next_cand_d;

    // Edge replication: line 0 reuses itself above, the last usable line reuses itself below.
    always_comb begin
        prev_cand_d = cur_slot;
        next_cand_d = cur_slot;
        if (line_idx != '0) begin
            prev_cand_d = cur_slot - ONE;
        end
        if ((pending != '0) && (line_idx < LAST_IDX)) begin
            next_cand_d = cur_slot + ONE;
        end
    end

    always_ff @(posedge pxlClk) begin
        if (rst) begin
            prev_cand_q <= '0;
            next_cand_q <= '0;
            prev_slot   <= '0;
            next_slot   <= '0;
        end else begin
            prev_cand_q <= prev_cand_d;
            next_cand_q <= next_cand_d;
            if (cache_update) begin
                prev_slot <= prev_cand_q;
                next_slot <= next_cand_q;
            end
        end
    end

endmodule

// File: rtl/line_ring_sched.sv
// Schedules the GBA line-cache ring between the capture-side writer and the
// HDMI-side 3x3 reader: assigns the write slot and prev/cur/next read slots,
// flags when the reader must repeat a line, and issues the frame-start pulse
// that locks HDMI output to the GBA frame.
// Ports: pxlClk, rst (sync, active-high), bus (slave side of line_ring_sched_if).
module line_ring_sched
    import line_ring_sched_pkg::*;
#(
    parameter int unsigned NUM_SLOTS       = LINE_SLOTS,
    parameter int unsigned LINES_PER_FRAME = GBA_LINES
) (
    input  logic             pxlClk,
    input  logic             rst,
    line_ring_sched_if.slave bus
);
    localparam int unsigned           SLOT_W   = $clog2(NUM_SLOTS);
    localparam logic [SLOT_W-1:0]     PEND_MAX = SLOT_W'(NUM_SLOTS - 2);
    localparam logic [SLOT_W-1:0]     ONE      = SLOT_W'(1);
    localparam logic [LINE_IDX_W-1:0] LAST_IDX = LINE_IDX_W'(LINES_PER_FRAME - 1);

    sched_state_t          state_q, state_d;
    logic [SLOT_W-1:0]     cur_q, cur_d;
    logic [SLOT_W-1:0]     wr_q, wr_d;
    logic [SLOT_W-1:0]     pend_q, pend_d;
    logic [LINE_IDX_W-1:0] idx_q, idx_d;
    logic                  ovf_q, ovf_d;
    logic                  nfo_q, nfo_d;
    logic                  same_q, same_d;
    logic                  adv_c;
    logic [SLOT_W-1:0]     eff_pend_c;

    // State register and ring bookkeeping.
    always_ff @(posedge pxlClk) begin
        if (rst) begin
            state_q <= IDLE;
            cur_q   <= '0;
            wr_q    <= '0;
            pend_q  <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            nfo_q   <= 1'b0;
            same_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            wr_q    <= wr_d;
            pend_q  <= pend_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
            nfo_q   <= nfo_d;
            same_q  <= same_d;
        end
    end

    // Next-state and ring update.
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        wr_d       = wr_q;
        pend_d     = pend_q;
        idx_d      = idx_q;
        ovf_d      = ovf_q;
        nfo_d      = 1'b0;
        adv_c      = (state_q == RUN) && bus.nextLine && (pend_q != '0) && (idx_q < LAST_IDX);
        // Occupancy as seen by the writer once a same-cycle read advance has freed a slot.
        eff_pend_c = pend_q - SLOT_W'(adv_c);
        same_d     = (state_q != RUN) || (pend_q == '0) || (idx_q == LAST_IDX);

        unique case (state_q)
            IDLE: begin
                wr_d = '0;
                if (bus.wrFrameStart) begin
                    state_d = PRIME;
                end
            end
            PRIME: begin
                if (bus.wrLineDone) begin
                    cur_d   = wr_q;
                    idx_d   = '0;
                    pend_d  = '0;
                    wr_d    = wr_q + ONE;
                    nfo_d   = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (adv_c) begin
                    cur_d  = cur_q + ONE;
                    idx_d  = idx_q + LINE_IDX_W'(1);
                    pend_d = eff_pend_c;
                end
                // A full ring drops the newest line: the writer refills the same slot.
                if (bus.wrLineDone) begin
                    if (eff_pend_c < PEND_MAX) begin
                        pend_d = eff_pend_c + ONE;
                        wr_d   = wr_q + ONE;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Resync lands after any same-cycle line completion; a bare restart of PRIME changes nothing.
        if (bus.wrFrameStart && (state_d == RUN)) begin
            state_d = PRIME;
            pend_d  = '0;
            ovf_d   = 1'b0;
            wr_d    = cur_d + ONE;
        end
    end

    line_ring_sched_slot_neighbour_calc #(
        .SLOT_W          (SLOT_W),
        .LINES_PER_FRAME (LINES_PER_FRAME)
    ) u_neighbour (
        .pxlClk       (pxlClk),
        .rst          (rst),
        .cache_update (bus.cacheUpdate),
        .cur_slot     (cur_q),
        .pending      (pend_q),
        .line_idx     (idx_q),
        .prev_slot    (bus.prevSlot),
        .next_slot    (bus.nextSlot)
    );

    assign bus.wrSlot      = wr_q;
    assign bus.curSlot     = cur_q;
    assign bus.lineIdx     = idx_q;
    assign bus.pending     = pend_q;
    assign bus.overflow    = ovf_q;
    assign bus.newFrameOut = nfo_q;
    assign bus.sameLine    = same_q;

endmodule

// File: tb/tb_line_ring_sched.sv
// Directed bench for line_ring_sched with a scoreboard of expected ring
// snapshots; inputs change and outputs are sampled on the falling edge.
module tb_line_ring_sched;
    import line_ring_sched_pkg::*;

    localparam int unsigned SLOT_W = $clog2(LINE_SLOTS);

    logic pxlClk = 1'b0;
    logic rst;

    line_ring_sched_if #(.SLOT_W(SLOT_W)) bus ();

    line_ring_sched #(
        .NUM_SLOTS       (LINE_SLOTS),
        .LINES_PER_FRAME (GBA_LINES)
    ) dut (
        .pxlClk (pxlClk),
        .rst    (rst),
        .bus    (bus)
    );

    always #5 pxlClk = ~pxlClk;

    typedef struct {
        string tag;
        int    cur;
        int    wr;
        int    pend;
        int    idx;
        int    same;
        int    ovf;
        int    prv;
        int    nxt;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input string tag, input int cur, input int wr, input int pend,
                            input int idx, input int same, input int ovf, input int prv, input int nxt);
        exp_t e;
        e.tag = tag; e.cur = cur; e.wr = wr; e.pend = pend; e.idx = idx;
        e.same = same; e.ovf = ovf; e.prv = prv; e.nxt = nxt;
        exp_q.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL scoreboard: observed=empty expected=entry");
            return;
        end
        e = exp_q.pop_front();
        cmp({e.tag, "/curSlot"},  32'(bus.curSlot),  e.cur);
        cmp({e.tag, "/wrSlot"},   32'(bus.wrSlot),   e.wr);
        cmp({e.tag, "/pending"},  32'(bus.pending),  e.pend);
        cmp({e.tag, "/lineIdx"},  32'(bus.lineIdx),  e.idx);
        cmp({e.tag, "/sameLine"}, 32'(bus.sameLine), e.same);
        cmp({e.tag, "/overflow"}, 32'(bus.overflow), e.ovf);
        cmp({e.tag, "/prevSlot"}, 32'(bus.prevSlot), e.prv);
        cmp({e.tag, "/nextSlot"}, 32'(bus.nextSlot), e.nxt);
    endtask

    // One clock of stimulus: drive at a falling edge, return at the next falling edge.
    task automatic cyc(input bit fs, input bit ld, input bit nl, input bit cu);
        bus.wrFrameStart = fs;
        bus.wrLineDone   = ld;
        bus.nextLine     = nl;
        bus.cacheUpdate  = cu;
        @(negedge pxlClk);
        bus.wrFrameStart = 1'b0;
        bus.wrLineDone   = 1'b0;
        bus.nextLine     = 1'b0;
        bus.cacheUpdate  = 1'b0;
    endtask

    task automatic settle();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 1);
    endtask

    task automatic settle_nocu();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
    endtask

    initial begin
        rst              = 1'b1;
        bus.wrFrameStart = 1'b0;
        bus.wrLineDone   = 1'b0;
        bus.nextLine     = 1'b0;
        bus.cacheUpdate  = 1'b0;
        @(negedge pxlClk);
        @(negedge pxlClk);
        rst = 1'b0;

        // Reset state, idle with no inputs
        push_exp("reset", 0, 0, 0, 0, 1, 0, 0, 0);
        pop_check();
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 0);
            cmp("idle_nfo", 32'(bus.newFrameOut), 0);
        end
        cmp("idle_same", 32'(bus.sameLine), 1);

        // Frame start, prime on first completed line
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 0, 0, 0);
        cmp("prime_nfo_quiet", 32'(bus.newFrameOut), 0);
        cyc(0, 1, 0, 0);
        cmp("prime_nfo_pulse", 32'(bus.newFrameOut), 1);
        cyc(0, 0, 0, 0);
        cmp("prime_nfo_drop", 32'(bus.newFrameOut), 0);
        push_exp("primed", 0, 1, 0, 0, 1, 0, 0, 0);
        settle();
        pop_check();

        // Two lines written, one read; neighbours wait for cacheUpdate
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cmp("adv_cur", 32'(bus.curSlot), 1);
        cmp("adv_idx", 32'(bus.lineIdx), 1);
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        cmp("gate_next", 32'(bus.nextSlot), 0);
        push_exp("advance", 1, 3, 1, 1, 0, 0, 0, 2);
        cyc(0, 0, 0, 1);
        pop_check();

        // Fill to capacity then overflow
        cyc(0, 1, 0, 0);
        cmp("fill_ovf", 32'(bus.overflow), 0);
        cmp("fill_wr", 32'(bus.wrSlot), 0);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        push_exp("overflow", 1, 0, 2, 1, 0, 1, 0, 2);
        settle();
        pop_check();

        // Simultaneous write and advance at full ring
        cyc(0, 1, 1, 0);
        push_exp("simul", 2, 1, 2, 2, 0, 1, 1, 3);
        settle();
        pop_check();

        // Resync in RUN clears overflow/pending, outputs hold
        cyc(1, 0, 0, 0);
        cmp("resync_nfo", 32'(bus.newFrameOut), 0);
        push_exp("resync", 2, 3, 0, 2, 1, 0, 1, 3);
        settle_nocu();
        pop_check();
        cyc(0, 1, 0, 0);
        cmp("reprime_nfo", 32'(bus.newFrameOut), 1);
        push_exp("reprimed", 3, 0, 0, 0, 1, 0, 3, 3);
        settle();
        pop_check();

        // Full frame with writer one line ahead
        cyc(0, 1, 0, 0);
        for (int i = 1; i < int'(GBA_LINES); i++) begin
            cyc(0, 1, 1, 0);
            cmp("frame_idx", 32'(bus.lineIdx), 32'(i));
            cmp("frame_cur", 32'(bus.curSlot), 32'((3 + i) % 4));
        end
        push_exp("last_line", 2, 0, 1, 159, 1, 0, 1, 2);
        settle();
        pop_check();
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        push_exp("last_hold", 2, 1, 2, 159, 1, 0, 1, 2);
        settle();
        pop_check();
        cyc(1, 0, 0, 0);
        cmp("eof_fs_nfo", 32'(bus.newFrameOut), 0);
        cyc(0, 0, 1, 0);
        push_exp("eof_prime", 2, 3, 0, 159, 1, 0, 1, 2);
        settle_nocu();
        pop_check();
        cyc(0, 1, 0, 0);
        cmp("eof_nfo", 32'(bus.newFrameOut), 1);
        cmp("eof_idx", 32'(bus.lineIdx), 0);
        cmp("eof_cur", 32'(bus.curSlot), 3);
        cyc(0, 0, 0, 0);
        cmp("eof_nfo_drop", 32'(bus.newFrameOut), 0);

        // Resync mid-frame at line 70
        cyc(0, 1, 0, 0);
        for (int i = 0; i < 70; i++) cyc(0, 1, 1, 0);
        push_exp("line70", 1, 3, 1, 70, 0, 0, 0, 2);
        settle();
        pop_check();
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        push_exp("mid_resync", 1, 2, 0, 70, 1, 0, 0, 2);
        settle_nocu();
        pop_check();
        cyc(0, 1, 0, 0);
        cmp("mid_nfo", 32'(bus.newFrameOut), 1);
        cmp("mid_idx", 32'(bus.lineIdx), 0);
        cmp("mid_cur", 32'(bus.curSlot), 2);
        cmp("mid_wr", 32'(bus.wrSlot), 3);
        cyc(0, 0, 0, 0);

        // Frame start while priming restarts without a pulse
        cyc(1, 0, 0, 0);
        cmp("restart1_nfo", 32'(bus.newFrameOut), 0);
        cyc(1, 0, 0, 0);
        cmp("restart2_nfo", 32'(bus.newFrameOut), 0);
        cmp("restart2_wr", 32'(bus.wrSlot), 3);
        cyc(0, 1, 0, 0);
        cmp("restart_nfo", 32'(bus.newFrameOut), 1);
        cmp("restart_cur", 32'(bus.curSlot), 3);
        cmp("restart_wr", 32'(bus.wrSlot), 0);

        // Reset mid-operation, then writer pulses ignored in IDLE
        cyc(0, 1, 0, 0);
        cmp("pre_rst_pend", 32'(bus.pending), 1);
        rst = 1'b1;
        cyc(0, 0, 0, 0);
        rst = 1'b0;
        push_exp("mid_reset", 0, 0, 0, 0, 1, 0, 0, 0);
        pop_check();
        cmp("mid_reset_nfo", 32'(bus.newFrameOut), 0);
        cyc(0, 1, 0, 0);
        push_exp("idle_ld", 0, 0, 0, 0, 1, 0, 0, 0);
        settle();
        pop_check();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
